// File: rtl/pu_pipe.sv
// pu_pipe: two-stage (IF/EX) pipelined processing unit with 8 registers.
// Define PU_MUL_EN to enable the single-cycle multiplier on opcode C.
module pu_pipe #(
    parameter int WIDTH = 16,
    parameter int PCW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PCW-1:0]   iaddr,
    input  logic [15:0]      idata,
    output logic             we,
    output logic [2:0]       wad,
    output logic [WIDTH-1:0] rwd,
    output logic             halted
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LIL  = 4'h8;
    localparam logic [3:0] OP_LIH  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
`ifdef PU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'hC;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [PCW-1:0]   pc;
    logic [15:0]      ir;
    logic [WIDTH-1:0] r [8];

    logic [3:0]       op;
    logic [2:0]       rd;
    logic [2:0]       ra;
    logic [2:0]       rb;
    logic [7:0]       imm8;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] vd;
    logic [WIDTH-1:0] res;
    logic             wr;
    logic             taken;
    logic             halt;

    assign op    = ir[15:12];
    assign rd    = ir[11:9];
    assign ra    = ir[8:6];
    assign rb    = ir[5:3];
    assign imm8  = ir[7:0];
    assign va    = r[ra];
    assign vb    = r[rb];
    assign vd    = r[rd];

    assign iaddr = pc;
    assign wad   = rd;
    assign rwd   = res;
    assign we    = en & ~halted & wr;

    // EX-stage decode and compute; non-writing ops leave res at zero
    always_comb begin
        res   = '0;
        wr    = 1'b0;
        taken = 1'b0;
        halt  = 1'b0;
        case (op)
            OP_ADD: begin
                res = va + vb;
                wr  = 1'b1;
            end
            OP_SUB: begin
                res = va - vb;
                wr  = 1'b1;
            end
            OP_AND: begin
                res = va & vb;
                wr  = 1'b1;
            end
            OP_OR: begin
                res = va | vb;
                wr  = 1'b1;
            end
            OP_XOR: begin
                res = va ^ vb;
                wr  = 1'b1;
            end
            OP_SHL: begin
                res = va << 1;
                wr  = 1'b1;
            end
            OP_SHR: begin
                res = va >> 1;
                wr  = 1'b1;
            end
            OP_LIL: begin
                res = WIDTH'(imm8);
                wr  = 1'b1;
            end
            OP_LIH: begin
                res = (vd << 8) | WIDTH'(imm8);
                wr  = 1'b1;
            end
            OP_BEQZ: taken = (vd == '0);
            OP_JMP:  taken = 1'b1;
`ifdef PU_MUL_EN
            OP_MUL: begin
                res = va * vb;
                wr  = 1'b1;
            end
`endif
            OP_HALT: halt = 1'b1;
            default: ;
        endcase
    end

    // IF stage: flush or halt in EX overrides the fetch latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else if (en && !halted) begin
            if (halt) begin
                halted <= 1'b1;
                ir     <= '0;
            end else if (taken) begin
                pc <= PCW'(imm8);
                ir <= '0;
            end else begin
                ir <= idata;
                pc <= pc + PCW'(1);
            end
        end
    end

    // Register write-back at the end of EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r[i] <= '0;
            end
        end else if (we) begin
            r[rd] <= res;
        end
    end

endmodule

// File: tb/tb_pu_pipe.sv
// tb_pu_pipe: instruction-level model predicts the ordered write stream;
// directed cycle checks cover reset, flush, halt and enable timing.
module tb_pu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [7:0]  iaddr;
    logic [15:0] idata;
    logic        we;
    logic [2:0]  wad;
    logic [15:0] rwd;
    logic        halted;

    logic [15:0] imem [256];
    logic [18:0] exp_q [$];
    bit          mon = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign idata = imem[iaddr];

    pu_pipe #(.WIDTH(16), .PCW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .iaddr  (iaddr),
        .idata  (idata),
        .we     (we),
        .wad    (wad),
        .rwd    (rwd),
        .halted (halted)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ISA-level model: executes the program sequentially, no pipeline
    task automatic run_model();
        logic [15:0] rf [8];
        logic [7:0]  pc;
        logic [15:0] ins, a, b, d, res;
        bit          w, stop;
        exp_q.delete();
        foreach (rf[i]) rf[i] = 16'h0;
        pc = 8'h0;
        stop = 1'b0;
        for (int s = 0; s < 1000 && !stop; s++) begin
            ins = imem[pc];
            a = rf[ins[8:6]];
            b = rf[ins[5:3]];
            d = rf[ins[11:9]];
            w = 1'b1;
            res = 16'h0;
            pc = pc + 8'd1;
            case (ins[15:12])
                4'h1: res = a + b;
                4'h2: res = a - b;
                4'h3: res = a & b;
                4'h4: res = a | b;
                4'h5: res = a ^ b;
                4'h6: res = {a[14:0], 1'b0};
                4'h7: res = {1'b0, a[15:1]};
                4'h8: res = {8'h00, ins[7:0]};
                4'h9: res = {d[7:0], ins[7:0]};
                4'hA: begin
                    w = 1'b0;
                    if (d == 16'h0) pc = ins[7:0];
                end
                4'hB: begin
                    w = 1'b0;
                    pc = ins[7:0];
                end
`ifdef PU_MUL_EN
                4'hC: res = a * b;
`endif
                4'hF: begin
                    w = 1'b0;
                    stop = 1'b1;
                end
                default: w = 1'b0;
            endcase
            if (w) begin
                rf[ins[11:9]] = res;
                exp_q.push_back({ins[11:9], res});
            end
        end
    endtask

    // Every observed write must be the next one the model predicts
    always @(negedge clk) begin
        if (mon && we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_write actual=%0h/%0h expected=none",
                         wad, rwd);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                chk("write_wad", 32'(wad), 32'(e[18:16]));
                chk("write_rwd", 32'(rwd), 32'(e[15:0]));
            end
        end
    end

    task automatic clear_mem();
        foreach (imem[i]) imem[i] = 16'h0000;
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        mon = 1'b0;
        en = 1'b1;
        rst = 1'b0;
        #1;
        chk({tag, "_iaddr"}, 32'(iaddr), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_wad"}, 32'(wad), 0);
        chk({tag, "_rwd"}, 32'(rwd), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        mon = 1'b1;
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk({tag, "_halt_reached"}, 32'(halted), 1);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 0);
        mon = 1'b0;
    endtask

    task automatic load_p1();
        clear_mem();
        imem[0] = 16'h8105;
        imem[1] = 16'h8207;
        imem[2] = 16'h1208;
        imem[3] = 16'h1440;
        imem[4] = 16'hF000;
    endtask

    logic [18:0] pin1 [4];
    logic [18:0] pin2 [10];
    logic [7:0]  ia;

    initial begin
        pin1 = '{{3'd0, 16'd5}, {3'd1, 16'd7}, {3'd1, 16'd12},
                 {3'd2, 16'd17}};
        pin2 = '{{3'd0, 16'h00FF}, {3'd0, 16'hFFFF}, {3'd1, 16'h0001},
                 {3'd0, 16'h0000}, {3'd2, 16'hFFFF}, {3'd3, 16'h0001},
                 {3'd4, 16'hFFFE}, {3'd5, 16'hFFFF}, {3'd6, 16'hFFFC},
                 {3'd7, 16'h7FFF}};

        // LIL sequence and first-write timing
        load_p1();
        run_model();
        chk("p1_model_len", 32'(exp_q.size()), 4);
        foreach (pin1[i]) chk("p1_model_pin", 32'(exp_q[i]), 32'(pin1[i]));
        reset_and_check("rst1");
        release_rst();
        @(negedge clk);
        chk("p1_c1_we", 32'(we), 1);
        chk("p1_c1_wad", 32'(wad), 0);
        chk("p1_c1_rwd", 32'(rwd), 5);
        chk("p1_c1_iaddr", 32'(iaddr), 1);
        @(negedge clk);
        chk("p1_c2_wad", 32'(wad), 1);
        chk("p1_c2_rwd", 32'(rwd), 7);
        @(negedge clk);
        chk("p1_c3_rwd", 32'(rwd), 12);
        run_until_halt("p1", 50);

        // ALU ops, LIH and wrap
        clear_mem();
        imem[0]  = 16'h80FF;
        imem[1]  = 16'h90FF;
        imem[2]  = 16'h8201;
        imem[3]  = 16'h1008;
        imem[4]  = 16'h2408;
        imem[5]  = 16'h3688;
        imem[6]  = 16'h5888;
        imem[7]  = 16'h4B18;
        imem[8]  = 16'h6D00;
        imem[9]  = 16'h7F00;
        imem[10] = 16'hF000;
        run_model();
        chk("p2_model_len", 32'(exp_q.size()), 10);
        foreach (pin2[i]) chk("p2_model_pin", 32'(exp_q[i]), 32'(pin2[i]));
        reset_and_check("rst2");
        release_rst();
        run_until_halt("p2", 50);

        // Branch flush, not-taken branch, JMP, HALT
        clear_mem();
        imem[8'h00] = 16'h8600;
        imem[8'h01] = 16'hA610;
        imem[8'h02] = 16'h8A55;
        imem[8'h10] = 16'h8C01;
        imem[8'h11] = 16'h8601;
        imem[8'h12] = 16'hA620;
        imem[8'h13] = 16'h8E07;
        imem[8'h14] = 16'hB030;
        imem[8'h15] = 16'h8A55;
        imem[8'h30] = 16'hF000;
        imem[8'h31] = 16'h8A55;
        run_model();
        chk("p3_model_len", 32'(exp_q.size()), 4);
        chk("p3_model_pin", 32'(exp_q[1]), 32'({3'd6, 16'd1}));
        reset_and_check("rst3");
        release_rst();
        @(negedge clk);
        chk("p3_c1_we", 32'(we), 1);
        @(negedge clk);
        chk("p3_beqz_we", 32'(we), 0);
        chk("p3_beqz_iaddr", 32'(iaddr), 8'h02);
        @(negedge clk);
        chk("p3_bubble_we", 32'(we), 0);
        chk("p3_target_iaddr", 32'(iaddr), 8'h10);
        @(negedge clk);
        chk("p3_tgt_we", 32'(we), 1);
        chk("p3_tgt_wad", 32'(wad), 6);
        @(negedge clk);
        @(negedge clk);
        chk("p3_nt_iaddr", 32'(iaddr), 8'h13);
        @(negedge clk);
        chk("p3_nt_we", 32'(we), 1);
        chk("p3_nt_wad", 32'(wad), 7);
        chk("p3_seq_iaddr", 32'(iaddr), 8'h14);
        @(negedge clk);
        @(negedge clk);
        chk("p3_jmp_iaddr", 32'(iaddr), 8'h30);
        chk("p3_jmp_we", 32'(we), 0);
        @(negedge clk);
        chk("p3_pre_halt", 32'(halted), 0);
        @(negedge clk);
        chk("p3_halted", 32'(halted), 1);
        chk("p3_halt_iaddr", 32'(iaddr), 8'h31);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p3_frozen_iaddr", 32'(iaddr), 8'h31);
            chk("p3_frozen_we", 32'(we), 0);
        end
        chk("p3_writes_left", 32'(exp_q.size()), 0);
        mon = 1'b0;
        reset_and_check("rst_after_halt");

        // Enable stall mid-program
        load_p1();
        run_model();
        release_rst();
        @(negedge clk);
        @(negedge clk);
        ia = iaddr;
        chk("p4_pre_iaddr", 32'(ia), 2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p4_stall_iaddr", 32'(iaddr), 32'(ia));
            chk("p4_stall_we", 32'(we), 0);
        end
        en = 1'b1;
        run_until_halt("p4", 50);

        // Opcode C, multiplier or NOP depending on build
        clear_mem();
        imem[0] = 16'h8201;
        imem[1] = 16'h922C;
        imem[2] = 16'h8401;
        imem[3] = 16'h942C;
        imem[4] = 16'hC650;
        imem[5] = 16'hF000;
        run_model();
`ifdef PU_MUL_EN
        chk("p5_model_len", 32'(exp_q.size()), 5);
        chk("p5_model_mul", 32'(exp_q[4]), 32'({3'd3, 16'd24464}));
`else
        chk("p5_model_len", 32'(exp_q.size()), 4);
        chk("p5_model_last", 32'(exp_q[3]), 32'({3'd2, 16'd300}));
`endif
        reset_and_check("rst5");
        release_rst();
        for (int i = 0; i < 5; i++) @(negedge clk);
`ifdef PU_MUL_EN
        chk("p5_mul_we", 32'(we), 1);
        chk("p5_mul_rwd", 32'(rwd), 24464);
`else
        chk("p5_c_we", 32'(we), 0);
        chk("p5_c_rwd", 32'(rwd), 0);
`endif
        run_until_halt("p5", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
